alu: RTL and testbench
======================

Name: alu

Overview:
- Parameterised integer ALU with registered outputs.
- Computes add, subtract, AND, OR, XOR, unsigned compare, and shift-left on operand A or B, selected by a 3-bit opcode.
- Sits in the datapath as a single-cycle-latency execution unit; operands and opcode are sampled each clock with no handshake.

Parameters:
- WIDTH, 8: operand and result width in bits. Legal range is 2 or more.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- opcode  input  3  operation select.
- ALU_OUT  output  WIDTH  registered result.
- C_Flag  output  1  registered compare flag.
- Cout  output  1  registered carry, borrow or shift-out bit.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: while rst_n=0, ALU_OUT=0, C_Flag=0 and Cout=0 immediately, independent of clk.
- After rst_n deasserts, the first update happens on the next rising clk edge.
- Latency: results of A/B/opcode sampled at clock edge N appear on the outputs after edge N and hold until edge N+1.
- There is no enable; every cycle updates all three outputs.
- Outputs depend only on the current registered sample; the design keeps no history.
- Opcode map (all arithmetic unsigned, modulo 2^WIDTH):
  - 000 ADD: ALU_OUT = A+B; Cout = carry out of bit WIDTH-1; C_Flag=0.
  - 001 SUB: ALU_OUT = A-B; Cout = borrow (1 when A<B); C_Flag=0.
  - 010 AND: ALU_OUT = A&B; Cout=0; C_Flag=0.
  - 011 OR: ALU_OUT = A|B; Cout=0; C_Flag=0.
  - 100 XOR: ALU_OUT = A^B; Cout=0; C_Flag=0.
  - 101 CMP: C_Flag = 1 when A>B (unsigned), else 0; ALU_OUT=0; Cout=0.
  - 110 SHL A: ALU_OUT = A shifted left by 1 with LSB filled 0; Cout = A[WIDTH-1]; C_Flag=0.
  - 111 SHL B: ALU_OUT = B shifted left by 1 with LSB filled 0; Cout = B[WIDTH-1]; C_Flag=0.
- C_Flag is cleared on every non-CMP operation. For A==B, CMP gives C_Flag=0.
- Wrap-around:
  - ADD of all-ones + 1 gives ALU_OUT=0, Cout=1.
  - SUB 0-1 gives all-ones, Cout=1.
- X/Z on opcode: the default branch produces ALU_OUT=0, C_Flag=0, Cout=0. No latches; a full case with default is required.
- Reset asserted mid-stream: outputs clear asynchronously. Operation resumes on the first rising edge after release, with no residual state.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_ADD=3'b000, OP_SUB=3'b001, OP_AND=3'b010, OP_OR=3'b011, OP_XOR=3'b100, OP_CMP=3'b101, OP_SHLA=3'b110, OP_SHLB=3'b111;
  - the default WIDTH constant.
- One sub-module, alu_core: purely combinational, producing next-state result, c_flag and cout from A, B and opcode.
- The top-level alu holds the output register bank with async active-low reset only.

Test Plan:
- Reset: rst_n=0 with arbitrary inputs -> ALU_OUT=0x00, C_Flag=0, Cout=0 with no clock. Release, then A=10, B=5, opcode=000 -> after one edge ALU_OUT=15, Cout=0.
- A=10, B=5 sequencing opcodes 001/010/011/100 -> ALU_OUT 5, 0, 15, 15 respectively. Cout=0 and C_Flag=0 each cycle.
- CMP, opcode=101:
  - A=15, B=9 -> C_Flag=1, ALU_OUT=0.
  - A=9, B=15 -> C_Flag=0.
  - A=B=7 -> C_Flag=0.
  - Next op ADD -> C_Flag returns to 0.
- Shifts:
  - opcode=110, A=0x5E -> ALU_OUT=0xBC, Cout=0.
  - opcode=110, A=0x81 -> ALU_OUT=0x02, Cout=1.
  - opcode=111, B=0x07 -> ALU_OUT=0x0E, Cout=0.
- Wrap/borrow:
  - ADD 200+100 -> ALU_OUT=44, Cout=1.
  - ADD 0xFF+0x01 -> 0x00, Cout=1.
  - SUB 3-5 -> 0xFE, Cout=1.
- Latency and reset mid-op: change opcode between edges -> outputs stay stable until the next edge. Assert rst_n low between edges -> outputs clear at once; the first result after release reflects the current inputs.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU: default datapath width and the opcode map.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_CMP  = 3'b101;
  localparam logic [2:0] OP_SHLA = 3'b110;
  localparam logic [2:0] OP_SHLB = 3'b111;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: computes the next result, compare flag and
// carry/borrow/shift-out bit from the current operands and opcode.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic [WIDTH-1:0] result,
  output logic             c_flag,
  output logic             cout
);

  // One extra bit on add/sub captures the carry out or the borrow.
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // Opcode decode; every branch assigns all three outputs, and the default
  // clears them so an unknown opcode never leaves stale values behind.
  always_comb begin
    result = '0;
    c_flag = 1'b0;
    cout   = 1'b0;
    case (opcode)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        cout   = sum[WIDTH];
      end
      OP_SUB: begin
        result = diff[WIDTH-1:0];
        cout   = diff[WIDTH];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_CMP: c_flag = (a > b);
      OP_SHLA: begin
        result = {a[WIDTH-2:0], 1'b0};
        cout   = a[WIDTH-1];
      end
      OP_SHLB: begin
        result = {b[WIDTH-2:0], 1'b0};
        cout   = b[WIDTH-1];
      end
      default: begin
        result = '0;
        c_flag = 1'b0;
        cout   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu.sv
// Single-cycle-latency ALU: combinational core followed by one output
// register bank. Operands and opcode are sampled every clock; there is no
// handshake and no enable, so each rising edge updates all outputs.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       opcode,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic             C_Flag,
  output logic             Cout
);

  logic [WIDTH-1:0] next_result;
  logic             next_c_flag;
  logic             next_cout;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (A),
    .b      (B),
    .opcode (opcode),
    .result (next_result),
    .c_flag (next_c_flag),
    .cout   (next_cout)
  );

  // Output register bank; reset clears it immediately, independent of clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALU_OUT <= '0;
      C_Flag  <= 1'b0;
      Cout    <= 1'b0;
    end else begin
      ALU_OUT <= next_result;
      C_Flag  <= next_c_flag;
      Cout    <= next_cout;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for the ALU: directed vector table, hand-written
// latency/reset sequences, and randomized vectors checked against an
// arithmetic reference model through an expected-value queue.
module tb_alu;

  localparam int WIDTH = 8;
  localparam int EW    = WIDTH + 2;
  localparam int MOD   = 1 << WIDTH;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] alu_out;
  logic             c_flag;
  logic             cout;

  int total;
  int bad;

  // Expected outputs packed as {ALU_OUT, C_Flag, Cout}.
  logic [EW-1:0] exp_q[$];

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic [WIDTH-1:0] r;
    logic             c;
    logic             co;
  } vec_t;

  vec_t vecs[$];

  alu #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .A       (a),
    .B       (b),
    .opcode  (opcode),
    .ALU_OUT (alu_out),
    .C_Flag  (c_flag),
    .Cout    (cout)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, bench did not complete");
    $fatal(1, "watchdog");
  end

  // Reference model: spec rules expressed with plain integer arithmetic.
  function automatic logic [EW-1:0] model(input int ia, input int ib, input int op);
    int  r;
    bit  c;
    bit  co;
    logic [WIDTH-1:0] rv;
    r = 0; c = 0; co = 0;
    case (op)
      0: begin r = ia + ib; co = (r >= MOD); r = r % MOD; end
      1: begin co = (ia < ib); r = (ia - ib + MOD) % MOD; end
      2: r = ia & ib;
      3: r = ia | ib;
      4: r = ia ^ ib;
      5: c = (ia > ib);
      6: begin co = (ia >= MOD / 2); r = (ia * 2) % MOD; end
      default: begin co = (ib >= MOD / 2); r = (ib * 2) % MOD; end
    endcase
    rv = r[WIDTH-1:0];
    return {rv, c, co};
  endfunction

  task automatic check(input string name, input logic [EW-1:0] exp);
    logic [EW-1:0] act;
    act = {alu_out, c_flag, cout};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got out=%h c_flag=%b cout=%b, expected out=%h c_flag=%b cout=%b",
               name, act[EW-1:2], act[1], act[0], exp[EW-1:2], exp[1], exp[0]);
    end
  endtask

  // Driver: present inputs on the falling edge, return just after the
  // rising edge that captures them.
  task automatic drive(input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db,
                       input logic [2:0] dop);
    @(negedge clk);
    a      = da;
    b      = db;
    opcode = dop;
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                         input logic [2:0] vop, input logic [WIDTH-1:0] vr,
                         input logic vc, input logic vco);
    vec_t v;
    v.a = va; v.b = vb; v.op = vop; v.r = vr; v.c = vc; v.co = vco;
    vecs.push_back(v);
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Directed table: {A, B, opcode, ALU_OUT, C_Flag, Cout}
    add_vec(8'd10,  8'd5,   3'b001, 8'd5,   1'b0, 1'b0);
    add_vec(8'd10,  8'd5,   3'b010, 8'd0,   1'b0, 1'b0);
    add_vec(8'd10,  8'd5,   3'b011, 8'd15,  1'b0, 1'b0);
    add_vec(8'd10,  8'd5,   3'b100, 8'd15,  1'b0, 1'b0);
    add_vec(8'd15,  8'd9,   3'b101, 8'd0,   1'b1, 1'b0);
    add_vec(8'd1,   8'd2,   3'b000, 8'd3,   1'b0, 1'b0);
    add_vec(8'd9,   8'd15,  3'b101, 8'd0,   1'b0, 1'b0);
    add_vec(8'd7,   8'd7,   3'b101, 8'd0,   1'b0, 1'b0);
    add_vec(8'hFF,  8'hFE,  3'b101, 8'd0,   1'b1, 1'b0);
    add_vec(8'h5E,  8'h33,  3'b110, 8'hBC,  1'b0, 1'b0);
    add_vec(8'h81,  8'h00,  3'b110, 8'h02,  1'b0, 1'b1);
    add_vec(8'hFF,  8'h07,  3'b111, 8'h0E,  1'b0, 1'b0);
    add_vec(8'h00,  8'hC3,  3'b111, 8'h86,  1'b0, 1'b1);
    add_vec(8'd200, 8'd100, 3'b000, 8'd44,  1'b0, 1'b1);
    add_vec(8'hFF,  8'h01,  3'b000, 8'h00,  1'b0, 1'b1);
    add_vec(8'd3,   8'd5,   3'b001, 8'hFE,  1'b0, 1'b1);
    add_vec(8'd0,   8'd1,   3'b001, 8'hFF,  1'b0, 1'b1);
    add_vec(8'hF0,  8'h3C,  3'b100, 8'hCC,  1'b0, 1'b0);

    // Reset with arbitrary inputs, checked before any clock edge.
    rst_n  = 1'b0;
    a      = 8'hA7;
    b      = 8'h5B;
    opcode = 3'b000;
    #2;
    check("reset_no_clock", '0);
    @(posedge clk);
    #1;
    check("reset_held_over_edge", '0);
    @(negedge clk);
    rst_n = 1'b1;

    // First operation after release.
    drive(8'd10, 8'd5, 3'b000);
    check("first_add_after_reset", {8'd15, 1'b0, 1'b0});

    // Directed table.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].op);
      check($sformatf("vec%0d", i), {vecs[i].r, vecs[i].c, vecs[i].co});
    end

    // Latency: inputs changed between edges must not disturb the outputs.
    drive(8'd40, 8'd2, 3'b000);
    check("latency_first", {8'd42, 1'b0, 1'b0});
    #2;
    a = 8'd1; b = 8'd9; opcode = 3'b001;
    #1;
    check("latency_hold_after_change", {8'd42, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    check("latency_next_edge", {8'd248, 1'b0, 1'b1});

    // Reset mid-stream between edges.
    drive(8'd20, 8'd30, 3'b000);
    check("pre_midreset", {8'd50, 1'b0, 1'b0});
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_clear", '0);
    a = 8'd7; b = 8'd3; opcode = 3'b101;
    @(negedge clk);
    check("midreset_held", '0);
    #2;
    rst_n = 1'b1;
    #1;
    check("midreset_released_no_edge", '0);
    @(posedge clk);
    #1;
    check("midreset_first_result", {8'd0, 1'b1, 1'b0});

    // Randomized vectors against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic [2:0]       rop;
      ra  = WIDTH'($urandom_range(0, MOD - 1));
      rb  = WIDTH'($urandom_range(0, MOD - 1));
      rop = 3'($urandom_range(0, 7));
      if (i % 16 == 0) rb = ra;
      exp_q.push_back(model(int'(ra), int'(rb), int'(rop)));
      drive(ra, rb, rop);
      check($sformatf("rand%0d_op%0d", i, rop), exp_q.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
